// File: rtl/xb_msg_sched.sv
// bus_clk-side scheduler for the PC<->FPGA message crossbar: splits inbound
// pixel words from coefficient bursts and round-robins outbound status words.
module xb_msg_sched #(
    parameter int XB_SIZE     = 32,
    parameter int COEFF_WORDS = 16,
    parameter int N_REQ       = 4
) (
    input  logic                     bus_clk,
    input  logic                     reset,
    input  logic                     cfg_enable,
    input  logic                     pc_msg_empty,
    input  logic [XB_SIZE-1:0]       pc_msg,
    output logic                     pc_msg_ack,
    input  logic                     pix_full,
    output logic                     pix_wren,
    input  logic                     dram_full,
    output logic                     dram_wren,
    output logic [XB_SIZE-1:0]       xb_dout,
    output logic                     coeff_done,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*XB_SIZE-1:0] req_msg,
    output logic [N_REQ-1:0]         gnt,
    input  logic                     fpga_msg_full,
    output logic                     fpga_msg_valid,
    output logic [XB_SIZE-1:0]       fpga_msg
);

    localparam int CW = $clog2(COEFF_WORDS);
    localparam int PW = $clog2(N_REQ);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COEFF = 1'b1;

    logic [0:0]         r_state;
    logic [CW-1:0]      r_word_ctr;
    logic               r_e_flag;
    logic               r_pix_wren;
    logic               r_dram_wren;
    logic               r_coeff_done;
    logic [XB_SIZE-1:0] r_xb_dout;

    logic [PW-1:0]      r_rr_ptr;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_fpga_valid;
    logic [XB_SIZE-1:0] r_fpga_msg;

    logic               w_ack;
    logic [N_REQ-1:0]   w_req_m;
    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW:0]        w_sum;
    logic [PW:0]        w_idx;
    logic [PW-1:0]      w_nxt_ptr;

    // Either full flag stalls the pop so a blocked path never loses a word.
    assign w_ack = !pc_msg_empty && !pix_full && !dram_full &&
                   !((r_state == S_IDLE) && !cfg_enable);

    assign pc_msg_ack     = w_ack;
    assign pix_wren       = r_pix_wren;
    assign dram_wren      = r_dram_wren;
    assign xb_dout        = r_xb_dout;
    assign coeff_done     = r_coeff_done;
    assign gnt            = r_gnt;
    assign fpga_msg_valid = r_fpga_valid;
    assign fpga_msg       = r_fpga_msg;

    // Inbound classifier: routes each popped word to the pixel or DRAM FIFO.
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_word_ctr   <= {CW{1'b0}};
            r_e_flag     <= 1'b0;
            r_pix_wren   <= 1'b0;
            r_dram_wren  <= 1'b0;
            r_coeff_done <= 1'b0;
            r_xb_dout    <= {XB_SIZE{1'b0}};
        end else begin
            r_pix_wren   <= 1'b0;
            r_dram_wren  <= 1'b0;
            r_coeff_done <= 1'b0;
            if (w_ack) begin
                r_xb_dout <= pc_msg;
                case (r_state)
                    S_IDLE: begin
                        if (pc_msg[0]) begin
                            r_dram_wren <= 1'b1;
                            r_word_ctr  <= {{(CW-1){1'b0}}, 1'b1};
                            r_e_flag    <= pc_msg[1];
                            r_state     <= S_COEFF;
                        end else begin
                            r_pix_wren  <= 1'b1;
                        end
                    end
                    S_COEFF: begin
                        // Inside a burst bit0 is payload, not a new start marker.
                        r_dram_wren <= 1'b1;
                        if (r_word_ctr == CW'(COEFF_WORDS - 1)) begin
                            r_word_ctr   <= {CW{1'b0}};
                            r_coeff_done <= r_e_flag;
                            r_state      <= S_IDLE;
                        end else begin
                            r_word_ctr   <= r_word_ctr + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_word_ctr <= {CW{1'b0}};
                    end
                endcase
            end else begin
                r_xb_dout <= r_xb_dout;
            end
        end
    end

    // Round-robin search from r_rr_ptr; the just-granted requester is masked
    // for the cycle its gnt is visible, since its req has not dropped yet.
    always_comb begin
        w_req_m = req & ~r_gnt;
        w_found = 1'b0;
        w_win   = {PW{1'b0}};
        w_sum   = {(PW+1){1'b0}};
        w_idx   = {(PW+1){1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            w_sum   = {1'b0, r_rr_ptr} + (PW+1)'(k);
            w_idx   = (w_sum >= (PW+1)'(N_REQ)) ? (w_sum - (PW+1)'(N_REQ)) : w_sum;
            w_win   = (!w_found && w_req_m[w_idx[PW-1:0]]) ? w_idx[PW-1:0] : w_win;
            w_found = w_found | w_req_m[w_idx[PW-1:0]];
        end
        w_nxt_ptr = (w_win == PW'(N_REQ - 1)) ? {PW{1'b0}} : (w_win + {{(PW-1){1'b0}}, 1'b1});
    end

    // Outbound grant register: one word per cycle onto fpga_msg.
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= {PW{1'b0}};
            r_gnt        <= {N_REQ{1'b0}};
            r_fpga_valid <= 1'b0;
            r_fpga_msg   <= {XB_SIZE{1'b0}};
        end else begin
            if (!fpga_msg_full && w_found) begin
                r_gnt        <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
                r_fpga_valid <= 1'b1;
                r_fpga_msg   <= req_msg[w_win*XB_SIZE +: XB_SIZE];
                r_rr_ptr     <= w_nxt_ptr;
            end else begin
                r_gnt        <= {N_REQ{1'b0}};
                r_fpga_valid <= 1'b0;
                r_fpga_msg   <= r_fpga_msg;
                r_rr_ptr     <= r_rr_ptr;
            end
        end
    end

endmodule

// File: tb/tb_xb_msg_sched.sv
// Directed bench for xb_msg_sched: inbound split, bursts, backpressure,
// round-robin arbitration, mid-burst reset and cfg_enable drop.
module tb_xb_msg_sched;

    logic         bus_clk = 1'b0;
    logic         reset;
    logic         cfg_enable;
    logic         pc_msg_empty;
    logic [31:0]  pc_msg;
    logic         pc_msg_ack;
    logic         pix_full;
    logic         pix_wren;
    logic         dram_full;
    logic         dram_wren;
    logic [31:0]  xb_dout;
    logic         coeff_done;
    logic [3:0]   req;
    logic [127:0] req_msg;
    logic [3:0]   gnt;
    logic         fpga_msg_full;
    logic         fpga_msg_valid;
    logic [31:0]  fpga_msg;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [31:0]  q[$];
    logic         ack_seen;
    logic [31:0]  word_seen;
    int           n_dram;
    int           n_pix;

    xb_msg_sched #(.XB_SIZE(32), .COEFF_WORDS(16), .N_REQ(4)) dut (
        .bus_clk(bus_clk), .reset(reset), .cfg_enable(cfg_enable),
        .pc_msg_empty(pc_msg_empty), .pc_msg(pc_msg), .pc_msg_ack(pc_msg_ack),
        .pix_full(pix_full), .pix_wren(pix_wren), .dram_full(dram_full),
        .dram_wren(dram_wren), .xb_dout(xb_dout), .coeff_done(coeff_done),
        .req(req), .req_msg(req_msg), .gnt(gnt), .fpga_msg_full(fpga_msg_full),
        .fpga_msg_valid(fpga_msg_valid), .fpga_msg(fpga_msg)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the FWFT source: present head, sample ack, clock, pop.
    task automatic step();
        pc_msg_empty = (q.size() == 0);
        pc_msg       = (q.size() == 0) ? 32'h0000_0000 : q[0];
        #1;
        ack_seen  = pc_msg_ack;
        word_seen = pc_msg;
        @(posedge bus_clk);
        #1;
        if (ack_seen && q.size() != 0) void'(q.pop_front());
        if (dram_wren) n_dram++;
        if (pix_wren)  n_pix++;
    endtask

    task automatic push_burst(input logic [31:0] first, input logic [31:0] base);
        q.push_back(first);
        for (int i = 1; i < 16; i++) q.push_back(base + 32'(i * 4) + ((i == 5) ? 32'h1 : 32'h0));
    endtask

    initial begin
        reset = 1'b1; cfg_enable = 1'b1; pc_msg_empty = 1'b1; pc_msg = 32'h0;
        pix_full = 1'b0; dram_full = 1'b0; req = 4'b0000; fpga_msg_full = 1'b0;
        for (int i = 0; i < 4; i++) req_msg[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        n_dram = 0; n_pix = 0;
        #12;
        chk("rst_pix_wren", {31'd0, pix_wren}, 32'd0);
        chk("rst_dram_wren", {31'd0, dram_wren}, 32'd0);
        chk("rst_xb_dout", xb_dout, 32'd0);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_fpga_msg", fpga_msg, 32'd0);
        reset = 1'b0;
        @(posedge bus_clk); #1;

        // 1: three DN words
        q.push_back(32'h0000_0010); q.push_back(32'h0000_0030); q.push_back(32'hA5A5_0020);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dn_ack", {31'd0, ack_seen}, 32'd1);
            chk("dn_pix_wren", {31'd0, pix_wren}, 32'd1);
            chk("dn_dram_wren", {31'd0, dram_wren}, 32'd0);
            chk("dn_xb_dout", xb_dout, word_seen);
        end
        step();
        chk("dn_idle_ack", {31'd0, ack_seen}, 32'd0);
        chk("dn_idle_pix", {31'd0, pix_wren}, 32'd0);

        // 2: burst with E=1
        n_dram = 0; n_pix = 0;
        push_burst(32'h0000_1003, 32'h2000_0000);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("burst_ack", {31'd0, ack_seen}, 32'd1);
            chk("burst_dram_wren", {31'd0, dram_wren}, 32'd1);
            chk("burst_xb_dout", xb_dout, word_seen);
            chk("burst_coeff_done", {31'd0, coeff_done}, (i == 15) ? 32'd1 : 32'd0);
        end
        chk("burst_dram_count", 32'(n_dram), 32'd16);
        chk("burst_pix_count", 32'(n_pix), 32'd0);
        step();
        chk("burst_after_done", {31'd0, coeff_done}, 32'd0);
        chk("burst_after_dram", {31'd0, dram_wren}, 32'd0);

        // 3: pix_full stall mid-burst, E=0
        n_dram = 0; n_pix = 0;
        push_burst(32'h0000_0001, 32'h3000_0000);
        for (int i = 0; i < 8; i++) step();
        pix_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_stall_ack", {31'd0, ack_seen}, 32'd0);
            chk("bp_stall_dram", {31'd0, dram_wren}, 32'd0);
        end
        pix_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("bp_resume_ack", {31'd0, ack_seen}, 32'd1);
        end
        chk("bp_coeff_done_e0", {31'd0, coeff_done}, 32'd0);
        chk("bp_dram_count", 32'(n_dram), 32'd16);
        chk("bp_pix_count", 32'(n_pix), 32'd0);
        step();
        chk("bp_drained_dram", {31'd0, dram_wren}, 32'd0);

        // 4: round-robin arbiter
        req = 4'b1111;
        step(); chk("arb_g1", {28'd0, gnt}, 32'h1); chk("arb_m1", fpga_msg, 32'hC0DE_0000);
        chk("arb_v1", {31'd0, fpga_msg_valid}, 32'd1);
        step(); chk("arb_g2", {28'd0, gnt}, 32'h2); chk("arb_m2", fpga_msg, 32'hC0DE_0001);
        step(); chk("arb_g3", {28'd0, gnt}, 32'h4); chk("arb_m3", fpga_msg, 32'hC0DE_0002);
        step(); chk("arb_g4", {28'd0, gnt}, 32'h8); chk("arb_m4", fpga_msg, 32'hC0DE_0003);
        step(); chk("arb_g5", {28'd0, gnt}, 32'h1);
        fpga_msg_full = 1'b1;
        step(); chk("arb_full_g", {28'd0, gnt}, 32'h0); chk("arb_full_v", {31'd0, fpga_msg_valid}, 32'd0);
        fpga_msg_full = 1'b0;
        step(); chk("arb_g6", {28'd0, gnt}, 32'h2); chk("arb_m6", fpga_msg, 32'hC0DE_0001);
        step(); chk("arb_g7", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        step(); chk("arb_noreq_g", {28'd0, gnt}, 32'h0); chk("arb_noreq_v", {31'd0, fpga_msg_valid}, 32'd0);

        // 5: reset after 7 burst words, then a DN word
        req = 4'b1001;
        push_burst(32'h0000_0003, 32'h5000_0000);
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_dram", {31'd0, dram_wren}, 32'd0);
        chk("mid_rst_pix", {31'd0, pix_wren}, 32'd0);
        chk("mid_rst_xb_dout", xb_dout, 32'd0);
        chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
        chk("mid_rst_valid", {31'd0, fpga_msg_valid}, 32'd0);
        q.delete();
        req = 4'b0000;
        @(posedge bus_clk); #2;
        chk("mid_rst_held_dram", {31'd0, dram_wren}, 32'd0);
        chk("mid_rst_held_fpga", fpga_msg, 32'd0);
        reset = 1'b0;
        q.push_back(32'h0000_0020);
        step();
        chk("post_rst_pix", {31'd0, pix_wren}, 32'd1);
        chk("post_rst_dram", {31'd0, dram_wren}, 32'd0);
        chk("post_rst_xb_dout", xb_dout, 32'h0000_0020);

        // 6: cfg_enable drop after 4 burst words
        n_dram = 0;
        push_burst(32'h0000_0003, 32'h6000_0000);
        q.push_back(32'h0000_0010); q.push_back(32'h0000_0030);
        for (int i = 0; i < 4; i++) step();
        cfg_enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("cfg_burst_ack", {31'd0, ack_seen}, 32'd1);
            chk("cfg_burst_dram", {31'd0, dram_wren}, 32'd1);
        end
        chk("cfg_coeff_done", {31'd0, coeff_done}, 32'd1);
        chk("cfg_dram_count", 32'(n_dram), 32'd16);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("cfg_off_ack", {31'd0, ack_seen}, 32'd0);
            chk("cfg_off_pix", {31'd0, pix_wren}, 32'd0);
        end
        chk("cfg_queue_kept", 32'(q.size()), 32'd2);
        cfg_enable = 1'b1;
        step();
        chk("cfg_on_ack", {31'd0, ack_seen}, 32'd1);
        chk("cfg_on_pix", {31'd0, pix_wren}, 32'd1);
        chk("cfg_on_xb_dout", xb_dout, 32'h0000_0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
